dcmi_psync_hs: RTL and testbench

- Multi-channel, lossless pulse synchronizer: each channel carries single-cycle event pulses from the sclk domain to the dclk domain.
- Uses a 2-phase req/ack handshake per channel.
- A per-channel pending counter absorbs bursts that arrive faster than the handshake round trip, so events are queued rather than dropped.
- Used in the DCMI path for frame/line/VSYNC event notifications crossing from the pixel clock to the system clock.

---
 rtl/dcmi_psync_hs.sv | 90 +++++++++
 tb/tb_dcmi_psync_hs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcmi_psync_hs.sv
// Multi-channel lossless pulse synchronizer: sclk event pulses cross to dclk over a 2-phase
// req/ack handshake, with a per-channel pending counter queueing bursts.
module dcmi_psync_hs #(
   parameter int unsigned NCH         = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic           srstn,
   input  logic           sclk,
   input  logic           drstn,
   input  logic           dclk,
   input  logic [NCH-1:0] sin,
   input  logic [NCH-1:0] sovf_clr,
   output logic [NCH-1:0] sbusy,
   output logic [NCH-1:0] sovf,
   output logic [NCH-1:0] dout
);

   localparam logic [CNT_W-1:0] PendMax = '1;
   localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      // Source-domain state
      logic                   req_q, req_d;
      logic [SYNC_STAGES-1:0] ack_sync_q;
      logic [CNT_W-1:0]       pend_q, pend_d;
      logic                   sovf_q, sovf_d;
      logic                   sbusy_q, sbusy_d;
      logic                   ack_s, idle, launch, drop;

      // Destination-domain state
      logic [SYNC_STAGES-1:0] req_sync_q;
      logic                   e_q;

      assign ack_s = ack_sync_q[SYNC_STAGES-1];

      always_comb begin
         idle    = (req_q == ack_s);
         launch  = idle & (sin[c] | (pend_q != '0));
         req_d   = req_q ^ launch;
         drop    = 1'b0;
         pend_d  = pend_q;
         if (sin[c] && !launch) begin
            if (pend_q == PendMax) begin
               drop = 1'b1;
            end else begin
               pend_d = pend_q + PendOne;
            end
         end else if (!sin[c] && launch) begin
            pend_d = pend_q - PendOne;
         end
         // Set beats clear when both happen in the same cycle.
         sovf_d  = drop | (sovf_q & ~sovf_clr[c]);
         // Busy looks ahead at the synchronized ack the next edge will present.
         sbusy_d = (pend_d != '0) | (req_d != ack_sync_q[SYNC_STAGES-2]);
      end

      always_ff @(posedge sclk or negedge srstn) begin
         if (!srstn) begin
            req_q      <= 1'b0;
            ack_sync_q <= '0;
            pend_q     <= '0;
            sovf_q     <= 1'b0;
            sbusy_q    <= 1'b0;
         end else begin
            req_q      <= req_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], e_q};
            pend_q     <= pend_d;
            sovf_q     <= sovf_d;
            sbusy_q    <= sbusy_d;
         end
      end

      always_ff @(posedge dclk or negedge drstn) begin
         if (!drstn) begin
            req_sync_q <= '0;
            e_q        <= 1'b0;
         end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            e_q        <= req_sync_q[SYNC_STAGES-1];
         end
      end

      // The edge flop doubles as the ack returned to the source domain.
      assign dout[c]  = req_sync_q[SYNC_STAGES-1] ^ e_q;
      assign sovf[c]  = sovf_q;
      assign sbusy[c] = sbusy_q;
   end

endmodule

// File: tb/tb_dcmi_psync_hs.sv
// Directed bench for dcmi_psync_hs: a 3-channel deep-queue instance and a 1-channel
// shallow-queue instance share clocks and resets.
module tb_dcmi_psync_hs;

   logic       sclk, dclk, srstn, drstn;
   logic [2:0] sin_a, clr_a, sbusy_a, sovf_a, dout_a;
   logic [0:0] sin_b, clr_b, sbusy_b, sovf_b, dout_b;

   int dhalf = 5;
   int dedge = 0;
   int cnt_a [3] = '{0, 0, 0};
   int cnt_b = 0;
   int passed = 0;
   int failed = 0;
   int total = 0;

   dcmi_psync_hs #(.NCH(3), .SYNC_STAGES(2), .CNT_W(4)) u_dut_a (
      .srstn(srstn), .sclk(sclk), .drstn(drstn), .dclk(dclk),
      .sin(sin_a), .sovf_clr(clr_a), .sbusy(sbusy_a), .sovf(sovf_a), .dout(dout_a)
   );

   dcmi_psync_hs #(.NCH(1), .SYNC_STAGES(2), .CNT_W(2)) u_dut_b (
      .srstn(srstn), .sclk(sclk), .drstn(drstn), .dclk(dclk),
      .sin(sin_b), .sovf_clr(clr_b), .sbusy(sbusy_b), .sovf(sovf_b), .dout(dout_b)
   );

   // sclk rises on even times, dclk on odd times, so the two never share an edge.
   initial begin
      sclk = 1'b0;
      forever #4 sclk = ~sclk;
   end

   initial begin
      dclk = 1'b0;
      #2;
      forever #(dhalf) dclk = ~dclk;
   end

   always @(posedge dclk) dedge <= dedge + 1;

   always @(negedge dclk) begin
      for (int c = 0; c < 3; c++) if (dout_a[c]) cnt_a[c] <= cnt_a[c] + 1;
      if (dout_b[0]) cnt_b <= cnt_b + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while ((sbusy_a != '0 || sbusy_b != '0) && n < budget) begin
         @(posedge sclk);
         #1;
         n++;
      end
      check(tag, (sbusy_a == '0 && sbusy_b == '0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int base0, base1, base2, base_b, d0, lat;
      int sent [3];
      logic [2:0] v;

      srstn = 1'b0; drstn = 1'b0;
      sin_a = '0; clr_a = '0; sin_b = '0; clr_b = '0;
      repeat (3) @(posedge sclk);
      #1;
      check("rst_sbusy_a", sbusy_a, 0);
      check("rst_sovf_a", sovf_a, 0);
      check("rst_dout_a", dout_a, 0);
      check("rst_sbusy_b", sbusy_b, 0);
      check("rst_sovf_b", sovf_b, 0);
      check("rst_dout_b", dout_b, 0);
      srstn = 1'b1; drstn = 1'b1;
      repeat (3) @(posedge sclk);
      #1;

      // Single pulse
      base0 = cnt_a[0];
      sin_a = 3'b001;
      @(posedge sclk);
      d0 = dedge;
      #1;
      sin_a = '0;
      check("single_sbusy_hi", sbusy_a, 3'b001);
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge dclk);
         if (dout_a[0]) begin
            lat = dedge - d0;
            break;
         end
      end
      check("single_latency_2to3", (lat >= 2 && lat <= 3) ? 32'd1 : 32'd0, 32'd1);
      wait_idle(100, "single_idle");
      check("single_count", cnt_a[0] - base0, 1);
      check("single_sovf", sovf_a, 0);

      // Burst of 10 into a 15-deep queue
      base0 = cnt_a[0];
      sin_a = 3'b001;
      repeat (10) @(posedge sclk);
      #1;
      sin_a = '0;
      check("burst_busy", sbusy_a, 3'b001);
      wait_idle(400, "burst_idle");
      check("burst_count", cnt_a[0] - base0, 10);
      check("burst_sovf", sovf_a, 0);

      // Continuous sin on ch1 straddles a launch edge while events are queued
      base0 = cnt_a[0]; base1 = cnt_a[1]; base2 = cnt_a[2];
      sin_a = 3'b010;
      repeat (3) @(posedge sclk);
      #1;
      sin_a = '0;
      repeat (2) @(posedge sclk);
      #1;
      sin_a = 3'b010;
      repeat (8) @(posedge sclk);
      #1;
      sin_a = '0;
      wait_idle(400, "same_cycle_idle");
      check("same_cycle_count", cnt_a[1] - base1, 11);
      check("same_cycle_ch0_quiet", cnt_a[0] - base0, 0);
      check("same_cycle_ch2_quiet", cnt_a[2] - base2, 0);

      // Slow destination from here on
      dhalf = 21;
      repeat (4) @(posedge sclk);
      #1;

      // Overflow on the 3-deep queue
      base_b = cnt_b;
      sin_b = 1'b1;
      repeat (6) @(posedge sclk);
      #1;
      sin_b = 1'b0;
      check("ovf_sovf_set", sovf_b, 1);
      check("ovf_busy", sbusy_b, 1);
      wait_idle(1000, "ovf_idle");
      check("ovf_count", cnt_b - base_b, 4);
      check("ovf_sticky", sovf_b, 1);
      clr_b = 1'b1;
      @(posedge sclk);
      #1;
      clr_b = 1'b0;
      check("ovf_cleared", sovf_b, 0);

      // Overflow and clear in the same cycle: set wins
      base_b = cnt_b;
      sin_b = 1'b1;
      repeat (5) @(posedge sclk);
      #1;
      clr_b = 1'b1;
      @(posedge sclk);
      #1;
      sin_b = 1'b0;
      clr_b = 1'b0;
      check("ovf_set_wins", sovf_b, 1);
      wait_idle(1000, "ovf2_idle");
      check("ovf2_count", cnt_b - base_b, 4);

      // Random traffic on three channels; at most 12 events each so no overflow
      base0 = cnt_a[0]; base1 = cnt_a[1]; base2 = cnt_a[2];
      sent = '{0, 0, 0};
      for (int i = 0; i < 300; i++) begin
         v = '0;
         for (int c = 0; c < 3; c++) begin
            if (sent[c] < 12 && $urandom_range(15) == 0) begin
               v[c] = 1'b1;
               sent[c]++;
            end
         end
         sin_a = v;
         @(posedge sclk);
         #1;
      end
      sin_a = '0;
      wait_idle(3000, "multi_idle");
      check("multi_count_ch0", cnt_a[0] - base0, sent[0]);
      check("multi_count_ch1", cnt_a[1] - base1, sent[1]);
      check("multi_count_ch2", cnt_a[2] - base2, sent[2]);
      check("multi_sovf", sovf_a, 0);

      // Reset with events queued and one in flight
      sin_a = 3'b001;
      repeat (5) @(posedge sclk);
      #1;
      sin_a = '0;
      @(posedge sclk);
      #1;
      check("pre_rst_busy", sbusy_a, 3'b001);
      check("pre_rst_sovf_b", sovf_b, 1);
      srstn = 1'b0; drstn = 1'b0;
      #1;
      check("midrst_sbusy_a", sbusy_a, 0);
      check("midrst_dout_a", dout_a, 0);
      check("midrst_sovf_b", sovf_b, 0);
      repeat (3) @(posedge sclk);
      #1;
      srstn = 1'b1; drstn = 1'b1;
      repeat (5) @(posedge sclk);
      #1;
      base0 = cnt_a[0];
      sin_a = 3'b001;
      @(posedge sclk);
      #1;
      sin_a = '0;
      wait_idle(300, "post_rst_idle");
      check("post_rst_count", cnt_a[0] - base0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
